alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Sequencing front end for the combinational ALU: accepts one decoded-register instruction per handshake, translates opcode/funct into the 5-bit ALU control code, and selects operands (register, sign/zero-extended immediate, shift amount). It holds those drives stable for the ALU's evaluation cycle and captures `res` or `zero` as the code requires. It presents the outcome (writeback data/destination or branch decision) on a valid/ready output handshake. It sits between the register-read stage and writeback/branch logic of the CPU datapath.

## Interface
- `XLEN`, 32: datapath width; instruction width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction + operands valid.
- `in_ready`  out  1  block accepts instruction this cycle.
- `in_instr`  in  32  fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- `in_rs_val`, `in_rt_val`  in  XLEN  register-file read values.
- `alu_num1`, `alu_num2`  out  XLEN  registered ALU operands.
- `alu_ctrl`  out  5  registered ALU control code.
- `alu_res`  in  XLEN  ALU result (combinational from above drives).
- `alu_zero`  in  1  ALU compare flag (meaningful only for codes 18–22).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  XLEN  captured `alu_res` (0 for branches/illegal).
- `out_dest`  out  5  writeback register: rd for R-type, rt for I-type, 0 otherwise.
- `out_we`  out  1  writeback enable (0 for branches, sw, illegal, dest 0).
- `out_branch`  out  1  instruction was a branch (codes 18–22).
- `out_taken`  out  1  captured `alu_zero` when `out_branch`, else 0.
- `out_illegal`  out  1  opcode/funct not in decode table.

## Operation
- FSM states: IDLE, EXEC, HOLD.
  - IDLE → EXEC on `in_valid & in_ready`.
  - EXEC → HOLD unconditionally.
  - In HOLD with `out_ready`: go to EXEC if `in_valid`, else IDLE.
- `in_ready = (state==IDLE) | (state==HOLD & out_ready)`.
- Decode at accept:
  - R-type (op 0), funct → code: 0x20→0 add, 0x22→1 sub, 0x18→2 mul, 0x00→3 sll, 0x02→4 srl, 0x01→5 sla, 0x03→6 sra, 0x21→7 addu, 0x08→8 pass, 0x24→9, 0x25→10, 0x26→11, 0x2A→12.
  - I-type op → code: 0x08→13 addi, 0x09→14 subi, 0x1C→15 muli, 0x23→16 lw, 0x2B→17 sw, 0x04→18 beq, 0x07→19 bgt, 0x06→20 blt, 0x05→21 bne, 0x01→22 beqz, 0x0F→23, 0x0D→24, 0x0C→25 andi, 0x0E→26 ori, 0x15→27 xori, 0x0A→28 slti.
- Operand select:
  - Codes 3–6: num1 = rt_val, num2 = zero-extended shamt.
  - Other R-type and branches: num1 = rs_val, num2 = rt_val.
  - Codes 25–27: num2 = zero-extended imm.
  - Other I-type: num2 = sign-extended imm.
  - Code 22: num2 = 0.
- Capture at end of EXEC:
  - Non-branch: `out_data <= alu_res`.
  - Branch: `out_taken <= alu_zero`, `out_data <= 0`.
  - Never sample `alu_zero` for non-branch codes, because the ALU retains a stale flag.
- Illegal: `alu_ctrl` driven 8, operands 0. Still traverses EXEC (uniform latency). `out_illegal=1`, `out_we=0`, `out_data=0`.
- `out_we` is 0 when the destination is register 0.

## Timing
- Reset (async, any state): state IDLE; all outputs 0, including `alu_num1`, `alu_num2` and `alu_ctrl` (code 0).
- Accept at edge N:
  - ALU drives valid during cycle N→N+1.
  - Capture at edge N+1.
  - `out_valid=1` from edge N+1 until the edge where `out_ready` is sampled high.
- Throughput: one instruction per 2 cycles. A HOLD handoff with `in_valid` starts the next EXEC with no bubble.
- Under backpressure: `alu_*` drives and all `out_*` stay stable while `out_valid & ~out_ready`.
- Reset asserted during EXEC or HOLD: in-flight instruction is dropped; no partial `out_valid`.

## Structure
- Package `alu_pkg` holds:
  - the 5-bit `alu_op_e` enum (codes 0–28 named as above);
  - opcode/funct localparams;
  - a `is_branch(code)` function;
  - the FSM state enum.
- One natural sub-module, `alu_decode`: combinational instruction → {code, operand-select, dest, we, branch, illegal}.
- The FSM and capture registers stay in `alu_issue_ctrl`.

## Test plan
- **R-type add:** add rs=5, rt=7 → `alu_ctrl=0`, `out_data=12`, `out_dest=rd`, `out_we=1`, `out_valid` at edge N+1.
- **Sign-extended immediate:** addi imm=0xFFFF, rs_val=10 → `alu_num2=0xFFFFFFFF`, `out_data=9`.
- **Zero-extended immediate:** andi imm=0x8000, rs_val=0xFFFFFFFF → `out_data=0x00008000`.
- **beq taken / not taken:** beq 3,3 → `out_branch=1`, `out_taken=1`, `out_we=0`. Then bne 3,3 → `out_taken=0`.
- **Backpressure:** hold `out_ready=0` for 5 cycles with `in_valid=1` → `in_ready=0` and outputs stable throughout. On release, the next instruction enters EXEC the same edge.
- **Illegal and reset mid-operation:**
  - Illegal: op 0x3F → `out_illegal=1`, `out_we=0`.
  - Reset: assert `rst` mid-EXEC → all outputs 0 immediately, `out_valid` never rises for that instruction.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue front end: control codes, opcode/funct
// values, operand-select kinds and the sequencing FSM states.
package alu_pkg;

  // 5-bit control code understood by the combinational ALU.
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,  ALU_SUB   = 5'd1,  ALU_MUL   = 5'd2,  ALU_SLL   = 5'd3,
    ALU_SRL   = 5'd4,  ALU_SLA   = 5'd5,  ALU_SRA   = 5'd6,  ALU_ADDU  = 5'd7,
    ALU_PASS  = 5'd8,  ALU_AND   = 5'd9,  ALU_OR    = 5'd10, ALU_XOR   = 5'd11,
    ALU_SLT   = 5'd12, ALU_ADDI  = 5'd13, ALU_SUBI  = 5'd14, ALU_MULI  = 5'd15,
    ALU_LW    = 5'd16, ALU_SW    = 5'd17, ALU_BEQ   = 5'd18, ALU_BGT   = 5'd19,
    ALU_BLT   = 5'd20, ALU_BNE   = 5'd21, ALU_BEQZ  = 5'd22, ALU_LUI   = 5'd23,
    ALU_IMM24 = 5'd24, ALU_ANDI  = 5'd25, ALU_ORI   = 5'd26, ALU_XORI  = 5'd27,
    ALU_SLTI  = 5'd28
  } alu_op_e;

  // R-type funct field values.
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLA  = 6'h01;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_PASS = 6'h08;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Opcode field values.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h09;
  localparam logic [5:0] OP_MULI  = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_BLT   = 6'h06;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BEQZ  = 6'h01;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_IMM24 = 6'h0D;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0E;
  localparam logic [5:0] OP_XORI  = 6'h15;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  // How the two ALU operands are formed from the instruction.
  typedef enum logic [2:0] {
    SEL_ZERO     = 3'd0,  // both operands 0 (illegal)
    SEL_RS_RT    = 3'd1,
    SEL_RT_SHAMT = 3'd2,
    SEL_RS_ZIMM  = 3'd3,
    SEL_RS_SIMM  = 3'd4,
    SEL_RS_ZERO  = 3'd5   // compare against zero
  } opsel_e;

  // Sequencing FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Codes whose result is the compare flag instead of alu_res.
  function automatic logic is_branch(input logic [4:0] code);
    return (code >= 5'd18) && (code <= 5'd22);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode: control code, operand select,
// writeback destination/enable, branch and illegal flags.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  code_o,
  output opsel_e      sel_o,
  output logic [4:0]  dest_o,
  output logic        we_o,
  output logic        branch_o,
  output logic        illegal_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       r_type;
  logic       legal;
  logic       writes;
  alu_op_e    code;
  logic       fields_unused;

  assign op     = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign r_type = (op == OP_RTYPE);
  // rs and shamt feed the operand mux in the parent, not the decode.
  assign fields_unused = ^{instr_i[25:21], instr_i[10:6]};

  // Opcode/funct table lookup; anything absent is illegal and drives PASS.
  always_comb begin
    code  = ALU_PASS;
    legal = 1'b1;
    if (r_type) begin
      case (funct)
        FN_ADD:  code = ALU_ADD;
        FN_SUB:  code = ALU_SUB;
        FN_MUL:  code = ALU_MUL;
        FN_SLL:  code = ALU_SLL;
        FN_SRL:  code = ALU_SRL;
        FN_SLA:  code = ALU_SLA;
        FN_SRA:  code = ALU_SRA;
        FN_ADDU: code = ALU_ADDU;
        FN_PASS: code = ALU_PASS;
        FN_AND:  code = ALU_AND;
        FN_OR:   code = ALU_OR;
        FN_XOR:  code = ALU_XOR;
        FN_SLT:  code = ALU_SLT;
        default: legal = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI:  code = ALU_ADDI;
        OP_SUBI:  code = ALU_SUBI;
        OP_MULI:  code = ALU_MULI;
        OP_LW:    code = ALU_LW;
        OP_SW:    code = ALU_SW;
        OP_BEQ:   code = ALU_BEQ;
        OP_BGT:   code = ALU_BGT;
        OP_BLT:   code = ALU_BLT;
        OP_BNE:   code = ALU_BNE;
        OP_BEQZ:  code = ALU_BEQZ;
        OP_LUI:   code = ALU_LUI;
        OP_IMM24: code = ALU_IMM24;
        OP_ANDI:  code = ALU_ANDI;
        OP_ORI:   code = ALU_ORI;
        OP_XORI:  code = ALU_XORI;
        OP_SLTI:  code = ALU_SLTI;
        default:  legal = 1'b0;
      endcase
    end
  end

  // Operand selection; beqz is checked first since it is also a branch.
  always_comb begin
    sel_o = SEL_ZERO;
    if (!legal)                                 sel_o = SEL_ZERO;
    else if (code >= ALU_SLL && code <= ALU_SRA) sel_o = SEL_RT_SHAMT;
    else if (code == ALU_BEQZ)                   sel_o = SEL_RS_ZERO;
    else if (r_type || is_branch(code))          sel_o = SEL_RS_RT;
    else if (code >= ALU_ANDI && code <= ALU_XORI) sel_o = SEL_RS_ZIMM;
    else                                         sel_o = SEL_RS_SIMM;
  end

  // Branches, stores and illegal instructions have no writeback register.
  assign branch_o  = legal & is_branch(code);
  assign illegal_o = ~legal;
  assign writes    = legal & ~branch_o & (code != ALU_SW);
  assign dest_o    = !writes ? 5'd0 : (r_type ? instr_i[15:11] : instr_i[20:16]);
  assign we_o      = writes & (dest_o != 5'd0);
  assign code_o    = code;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture sequencer around the combinational ALU.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and a producer holding valid keeps
// its payload unchanged until the transfer.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs_val,
  input  logic [XLEN-1:0] in_rt_val,
  output logic [XLEN-1:0] alu_num1,
  output logic [XLEN-1:0] alu_num2,
  output logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_dest,
  output logic            out_we,
  output logic            out_branch,
  output logic            out_taken,
  output logic            out_illegal,
  output logic [1:0]      dbg_state
);

  state_e          state_q, state_d;
  logic            accept;
  logic [4:0]      dec_code;
  opsel_e          dec_sel;
  logic [4:0]      dec_dest;
  logic            dec_we, dec_branch, dec_illegal;
  logic [XLEN-1:0] num1_d, num2_d;
  logic [XLEN-1:0] num1_q, num2_q;
  logic [4:0]      ctrl_q;
  logic [4:0]      pend_dest_q;
  logic            pend_we_q, pend_branch_q, pend_illegal_q;
  logic [XLEN-1:0] out_data_q;
  logic [4:0]      out_dest_q;
  logic            out_we_q, out_branch_q, out_taken_q, out_illegal_q;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
  assign accept   = in_valid & in_ready;

  alu_decode u_decode (
    .instr_i   (in_instr),
    .code_o    (dec_code),
    .sel_o     (dec_sel),
    .dest_o    (dec_dest),
    .we_o      (dec_we),
    .branch_o  (dec_branch),
    .illegal_o (dec_illegal)
  );

  // Operand mux feeding the ALU drive registers.
  always_comb begin
    num1_d = '0;
    num2_d = '0;
    case (dec_sel)
      SEL_RS_RT:    begin num1_d = in_rs_val; num2_d = in_rt_val; end
      SEL_RT_SHAMT: begin num1_d = in_rt_val; num2_d = {{(XLEN-5){1'b0}}, in_instr[10:6]}; end
      SEL_RS_ZIMM:  begin num1_d = in_rs_val; num2_d = {{(XLEN-16){1'b0}}, in_instr[15:0]}; end
      SEL_RS_SIMM:  begin num1_d = in_rs_val; num2_d = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]}; end
      SEL_RS_ZERO:  begin num1_d = in_rs_val; end
      default:      ;
    endcase
  end

  // Next-state logic: accept -> EXEC -> HOLD -> (EXEC on handoff | IDLE).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = in_valid ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ALU drives and decode metadata load only on accept, so they stay put
  // through EXEC and any backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num1_q         <= '0;
      num2_q         <= '0;
      ctrl_q         <= 5'd0;
      pend_dest_q    <= 5'd0;
      pend_we_q      <= 1'b0;
      pend_branch_q  <= 1'b0;
      pend_illegal_q <= 1'b0;
    end else if (accept) begin
      num1_q         <= num1_d;
      num2_q         <= num2_d;
      ctrl_q         <= dec_code;
      pend_dest_q    <= dec_dest;
      pend_we_q      <= dec_we;
      pend_branch_q  <= dec_branch;
      pend_illegal_q <= dec_illegal;
    end
  end

  // Result capture at the end of EXEC; the flag is only trusted for branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q    <= '0;
      out_dest_q    <= 5'd0;
      out_we_q      <= 1'b0;
      out_branch_q  <= 1'b0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      out_data_q    <= (pend_branch_q | pend_illegal_q) ? '0 : alu_res;
      out_dest_q    <= pend_dest_q;
      out_we_q      <= pend_we_q;
      out_branch_q  <= pend_branch_q;
      out_taken_q   <= pend_branch_q & alu_zero;
      out_illegal_q <= pend_illegal_q;
    end
  end

  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_ctrl    = ctrl_q;
  assign out_valid   = (state_q == ST_HOLD);
  assign out_data    = out_data_q;
  assign out_dest    = out_dest_q;
  assign out_we      = out_we_q;
  assign out_branch  = out_branch_q;
  assign out_taken   = out_taken_q;
  assign out_illegal = out_illegal_q;
  assign dbg_state   = state_q;

endmodule
